// File: rtl/multichannel_serializer.sv
// Multi-channel parallel-to-serial transmitter: per-channel word FIFOs drained
// round-robin, one whole word at a time, OUT_W bits per beat over valid/ready.
module multichannel_serializer #(
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 2,
    parameter int DEPTH    = 4,
    localparam int BEATS   = DATA_W / OUT_W,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [CHANNELS-1:0]        write_req,
    input  logic [CHANNELS*DATA_W-1:0] input_data,
    output logic [CHANNELS-1:0]        full,
    output logic [CHANNELS-1:0]        overflow,
    output logic [OUT_W-1:0]           output_data,
    output logic                       output_valid,
    input  logic                       output_ready,
    output logic                       output_last,
    output logic [CH_W-1:0]            output_channel
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] nonempty;
    logic [DATA_W-1:0]   head [CHANNELS];

    // ------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [CNT_W-1:0]  count_next;
        logic              full_q;
        logic              ovf_q;
        logic              push;

        // A full FIFO refuses the push even if it is popped on the same edge.
        assign push = write_req[i] && !full_q;

        always_comb begin
            count_next = count;
            if (push && !pop[i]) begin
                count_next = count + 1'b1;
            end else if (!push && pop[i]) begin
                count_next = count - 1'b1;
            end
        end

        // NOTE: storage has no reset; entries are only ever read behind count,
        // so clearing them would add reset fan-out without changing behaviour.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= input_data[i*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk or negedge arst) begin
            if (!arst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count  <= count_next;
                full_q <= (count_next == CNT_W'(DEPTH));
                if (write_req[i] && full_q) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign full[i]     = full_q;
        assign overflow[i] = ovf_q;
        assign nonempty[i] = (count != '0);
        assign head[i]     = mem[rd_ptr];
    end

    // ------------------------------------------------------------------
    // Round-robin selection: first non-empty channel after rr_ptr
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_next;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    rr_next;
    logic [CH_W-1:0]    chan;
    logic [CH_W-1:0]    chan_next;
    logic [DATA_W-1:0]  shift;
    logic [DATA_W-1:0]  shift_next;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  beat_next;
    logic [CH_W-1:0]    grant;
    logic               grant_valid;
    logic               load;
    logic               at_last;

    // Scan from farthest to nearest so the nearest candidate wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = CHANNELS; k >= 1; k--) begin
            if (nonempty[(int'(rr_ptr) + k) % CHANNELS]) begin
                grant       = CH_W'((int'(rr_ptr) + k) % CHANNELS);
                grant_valid = 1'b1;
            end
        end
    end

    assign at_last = (beat == BEAT_W'(BEATS - 1));

    // ------------------------------------------------------------------
    // Arbiter / shifter FSM
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        chan_next  = chan;
        shift_next = shift;
        beat_next  = beat;
        pop        = '0;
        load       = 1'b0;

        case (state)
            IDLE: begin
                load = grant_valid;
            end
            SHIFT: begin
                if (output_ready) begin
                    shift_next = shift >> OUT_W;
                    beat_next  = beat + 1'b1;
                    if (at_last) begin
                        load = grant_valid;
                        if (!grant_valid) begin
                            state_next = IDLE;
                            chan_next  = '0;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Loading a word never waits on output_ready.
        if (load) begin
            pop[grant] = 1'b1;
            shift_next = head[grant];
            chan_next  = grant;
            beat_next  = '0;
            rr_next    = grant;
            state_next = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state  <= IDLE;
            rr_ptr <= CH_W'(CHANNELS - 1);
            chan   <= '0;
            shift  <= '0;
            beat   <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_next;
            chan   <= chan_next;
            shift  <= shift_next;
            beat   <= beat_next;
        end
    end

    // Outputs come straight from state, and read as zero while idle.
    assign output_valid   = (state == SHIFT);
    assign output_data    = output_valid ? shift[OUT_W-1:0] : '0;
    assign output_last    = output_valid && at_last;
    assign output_channel = output_valid ? chan : '0;

endmodule

// File: tb/tb_multichannel_serializer.sv
// Scoreboard bench for multichannel_serializer: default and swept parameter sets
// run side by side, each against a queue-based word-level reference model.
module tb_multichannel_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int CH = (g == 0) ? 3 : 4;
        localparam int DW = (g == 0) ? 16 : 24;
        localparam int OW = (g == 0) ? 2 : 4;
        localparam int DP = (g == 0) ? 4 : 8;
        localparam int BT = DW / OW;
        localparam int CW = $clog2(CH);

        logic             arst;
        logic [CH-1:0]    write_req;
        logic [CH*DW-1:0] input_data;
        logic [CH-1:0]    full;
        logic [CH-1:0]    overflow;
        logic [OW-1:0]    output_data;
        logic             output_valid;
        logic             output_ready;
        logic             output_last;
        logic [CW-1:0]    output_channel;
        bit               done = 1'b0;

        multichannel_serializer #(
            .CHANNELS(CH), .DATA_W(DW), .OUT_W(OW), .DEPTH(DP)
        ) dut (
            .clk(clk), .arst(arst), .write_req(write_req), .input_data(input_data),
            .full(full), .overflow(overflow), .output_data(output_data),
            .output_valid(output_valid), .output_ready(output_ready),
            .output_last(output_last), .output_channel(output_channel)
        );

        // Reference model: queued words tagged with their channel, and the
        // beat stream each popped word must produce.
        int            q_ch[$];
        logic [DW-1:0] q_w[$];
        logic [OW-1:0] exp_d[$];
        int            exp_ch[$];
        bit            exp_last[$];
        int            m_skip = 0;
        bit            m_busy = 1'b0;
        int            m_left = 0;
        int            m_ptr = CH - 1;
        logic [CH-1:0] m_ovf = '0;
        int            rd = 0;
        int            words_out = 0;

        function automatic int chan_count(input int c);
            int n = 0;
            foreach (q_ch[k]) if (q_ch[k] == c) n++;
            return n;
        endfunction

        function automatic logic [CH-1:0] model_full();
            logic [CH-1:0] f;
            for (int c = 0; c < CH; c++) f[c] = (chan_count(c) == DP);
            return f;
        endfunction

        always @(posedge clk or negedge arst) begin : model
            int            sizes [CH];
            int            pick;
            int            k;
            bit            fin;
            logic [DW-1:0] w;
            if (!arst) begin
                q_ch.delete();
                q_w.delete();
                m_busy = 1'b0;
                m_left = 0;
                m_ptr  = CH - 1;
                m_ovf  = '0;
                m_skip = exp_d.size();
            end else begin
                for (int c = 0; c < CH; c++) sizes[c] = chan_count(c);
                fin = 1'b0;
                if (m_busy && output_ready) begin
                    m_left--;
                    fin = (m_left == 0);
                end
                if (!m_busy || fin) begin
                    pick = -1;
                    for (int s = 1; s <= CH; s++)
                        if (pick < 0 && sizes[(m_ptr + s) % CH] > 0) pick = (m_ptr + s) % CH;
                    m_busy = (pick >= 0);
                    if (pick >= 0) begin
                        k = 0;
                        while (q_ch[k] != pick) k++;
                        w = q_w[k];
                        q_ch.delete(k);
                        q_w.delete(k);
                        m_ptr  = pick;
                        m_left = BT;
                        for (int j = 0; j < BT; j++) begin
                            exp_d.push_back(w[j*OW +: OW]);
                            exp_ch.push_back(pick);
                            exp_last.push_back(j == BT - 1);
                        end
                    end
                end
                for (int c = 0; c < CH; c++) begin
                    if (write_req[c]) begin
                        if (sizes[c] == DP) m_ovf[c] = 1'b1;
                        else begin
                            q_ch.push_back(c);
                            q_w.push_back(input_data[c*DW +: DW]);
                        end
                    end
                end
            end
        end

        // Monitor: compares every presented beat, handshake and status flag.
        logic [OW+CW:0] hold = '0;
        bit             stalled = 1'b0;

        always @(negedge clk) begin : monitor
            if (rd < m_skip) rd = m_skip;
            check($sformatf("cfg%0d valid", g), 32'(output_valid), 32'(m_busy));
            check($sformatf("cfg%0d full", g), 32'(full), 32'(model_full()));
            check($sformatf("cfg%0d overflow", g), 32'(overflow), 32'(m_ovf));
            if (!output_valid) begin
                check($sformatf("cfg%0d idle outputs", g),
                      32'({output_data, output_last, output_channel}), 32'd0);
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check($sformatf("cfg%0d stall hold", g),
                          32'({output_data, output_last, output_channel}), 32'(hold));
                if (output_ready) begin
                    if (rd >= exp_d.size()) begin
                        check($sformatf("cfg%0d unexpected beat", g), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("cfg%0d data", g), 32'(output_data), 32'(exp_d[rd]));
                        check($sformatf("cfg%0d channel", g), 32'(output_channel), 32'(exp_ch[rd]));
                        check($sformatf("cfg%0d last", g), 32'(output_last), 32'(exp_last[rd]));
                        rd++;
                    end
                    if (output_last) words_out++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold    = {output_data, output_last, output_channel};
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        function automatic logic [CH*DW-1:0] place(input int c, input logic [DW-1:0] w);
            logic [CH*DW-1:0] v = '0;
            v[c*DW +: DW] = w;
            return v;
        endfunction

        task automatic push(input logic [CH-1:0] mask, input logic [CH*DW-1:0] data);
            write_req  = mask;
            input_data = data;
            tick();
            write_req  = '0;
        endtask

        task automatic drain(input string tag);
            int n = 0;
            write_req    = '0;
            output_ready = 1'b1;
            while ((m_busy || q_ch.size() != 0) && n < 3000) begin
                tick();
                n++;
            end
            tick();
            check($sformatf("cfg%0d %s drain in time", g, tag), 32'(n < 3000), 32'd1);
            check($sformatf("cfg%0d %s all beats seen", g, tag), 32'(rd), 32'(exp_d.size()));
        endtask

        initial begin : stim
            logic [CH*DW-1:0] all;
            int               w0;
            arst         = 1'b0;
            write_req    = '0;
            input_data   = '0;
            output_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("cfg%0d reset outputs", g),
                  32'({output_valid, output_last, output_data, output_channel}), 32'd0);
            check($sformatf("cfg%0d reset flags", g), 32'({full, overflow}), 32'd0);
            arst = 1'b1;

            // Single word, LSB-first.
            push(CH'(1), place(0, DW'(32'h5AA5C3)));
            drain("single");

            // Round robin across all channels, plus a second ch0 word mid-stream.
            all = '0;
            for (int c = 0; c < CH; c++) all[c*DW +: DW] = {(DW/4){4'(c + 1)}};
            push('1, all);
            push(CH'(1), place(0, DW'(32'hC0FFEE)));
            drain("round robin");

            // Overflow on ch1 while the sink stalls.
            output_ready = 1'b0;
            w0 = words_out;
            for (int i = 0; i < DP + 2; i++) push(CH'(2), place(1, DW'(32'h100 + i)));
            check($sformatf("cfg%0d ch1 full", g), 32'(full[1]), 32'd1);
            check($sformatf("cfg%0d ch1 overflow", g), 32'(overflow[1]), 32'd1);
            drain("overflow");
            check($sformatf("cfg%0d overflow words out", g), 32'(words_out - w0), 32'(DP + 1));

            // Backpressure pattern 1,0,0 during a word.
            push(CH'(4), place(2, DW'(32'h3CA596)));
            for (int i = 0; i < 3 * BT + 6; i++) begin
                output_ready = (i % 3 == 0);
                tick();
            end
            drain("backpressure");

            // Reset during beat 3 of a ch2 word, with stale ch0 data queued.
            push(CH'(4), place(2, DW'(32'h7E1DB4)));
            push(CH'(1), place(0, DW'(32'h0BADF0)));
            tick();
            tick();
            #2;
            arst = 1'b0;
            #1;
            check($sformatf("cfg%0d async reset outputs", g),
                  32'({output_valid, output_last, output_data, output_channel}), 32'd0);
            check($sformatf("cfg%0d async reset flags", g), 32'({full, overflow}), 32'd0);
            tick();
            arst = 1'b1;
            push(CH'(2), place(1, DW'(32'h4D2C1B)));
            drain("after reset");

            // Randomised pushes and sink readiness.
            for (int i = 0; i < 600; i++) begin
                for (int c = 0; c < CH; c++) begin
                    write_req[c]           = ($urandom_range(0, 3) == 0);
                    input_data[c*DW +: DW] = DW'($urandom);
                end
                output_ready = (i % 100 < 70) ? ($urandom_range(0, 3) != 0) : 1'b0;
                tick();
            end
            drain("random");
            done = 1'b1;
        end
    end

    initial begin : summary
        for (int i = 0; i < 60000 && !(cfg[0].done && cfg[1].done); i++) @(posedge clk);
        if (!(cfg[0].done && cfg[1].done)) begin
            checks++;
            errors++;
            $display("FAIL timeout: got unfinished stimulus, expected both configurations done");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
